ball_motion: RTL and testbench



---
 rtl/ball_motion.sv | 207 ++++++++++++++++++++
 tb/tb_ball_motion.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball trajectory integrator with position history.
// Launch latches a throw velocity; each frame update advances the ball under
// constant gravity with clamping at the right wall, ceiling and ground.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   update_i           one-cycle per-frame step pulse
//   launch_i           one-cycle throw / re-arm pulse
//   vel_x_i, vel_y_i   launch speeds (rightward, upward), unsigned
//   trail_idx_i        history entry to read (0 = head)
//   ball_x_o, ball_y_o head position (entry 0)
//   trail_x_o/_y_o     registered read of entry trail_idx_i, (0,0) if out of range
//   in_flight_o        state is FLIGHT
//   landed_o           state is LANDED
module ball_motion #(
  parameter int unsigned X_START   = 20,
  parameter int unsigned Y_GROUND  = 470,
  parameter int unsigned X_MAX     = 630,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned TRAIL_LEN = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       update_i,
  input  logic       launch_i,
  input  logic [9:0] vel_x_i,
  input  logic [9:0] vel_y_i,
  input  logic [3:0] trail_idx_i,
  output logic [9:0] ball_x_o,
  output logic [8:0] ball_y_o,
  output logic [9:0] trail_x_o,
  output logic [8:0] trail_y_o,
  output logic       in_flight_o,
  output logic       landed_o
);

  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned XNW = 11;
  localparam int unsigned YNW = 12;
  localparam int unsigned VYW = 11;

  localparam logic signed [YNW-1:0] Y_GROUND_S = YNW'(Y_GROUND);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_LANDED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]         tx_q [TRAIL_LEN];
  logic [YW-1:0]         ty_q [TRAIL_LEN];
  logic [XW-1:0]         vx_q, vx_d;
  logic signed [VYW-1:0] vy_q, vy_d;
  logic [XW-1:0]         trail_x_q, trail_x_d;
  logic [YW-1:0]         trail_y_q, trail_y_d;

  logic [XW-1:0]         head_x_d;
  logic [YW-1:0]         head_y_d;
  logic                  shift_en;
  logic                  refill;
  logic                  land;

  logic [XNW-1:0]        x_n;
  logic signed [YNW-1:0] y_n;
  logic signed [VYW-1:0] vy_n;
  logic                  hit_wall;
  logic                  hit_ceiling;
  logic                  hit_ground;

  // Candidate next position/velocity for one frame step
  always_comb begin
    x_n         = {1'b0, tx_q[0]} + {1'b0, vx_q};
    y_n         = $signed({3'b000, ty_q[0]}) - $signed({vy_q[VYW-1], vy_q});
    vy_n        = vy_q - VYW'(GRAVITY);
    hit_wall    = (x_n >= XNW'(X_MAX));
    hit_ceiling = (y_n < $signed(YNW'(0)));
    hit_ground  = (y_n >= Y_GROUND_S);
  end

  // Datapath next values: velocity latch, clamped step, trail control
  always_comb begin
    vx_d     = vx_q;
    vy_d     = vy_q;
    head_x_d = tx_q[0];
    head_y_d = ty_q[0];
    shift_en = 1'b0;
    refill   = 1'b0;
    land     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_i) begin
          vx_d = vel_x_i;
          vy_d = {1'b0, vel_y_i};
        end
      end
      S_FLIGHT: begin
        if (update_i) begin
          shift_en = 1'b1;
          land     = hit_wall | hit_ground;
          head_x_d = hit_wall ? XW'(X_MAX) : x_n[XW-1:0];
          if (hit_ceiling) begin
            // Ceiling kills upward speed; gravity resumes on the next step
            head_y_d = '0;
            vy_d     = '0;
          end else if (hit_ground) begin
            head_y_d = YW'(Y_GROUND);
            vy_d     = vy_n;
          end else begin
            head_y_d = y_n[YW-1:0];
            vy_d     = vy_n;
          end
        end
      end
      S_LANDED: begin
        if (launch_i) begin
          refill = 1'b1;
          vx_d   = '0;
          vy_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Trail read mux; out-of-range indices read as zero
  always_comb begin
    trail_x_d = '0;
    trail_y_d = '0;
    for (int k = 0; k < TRAIL_LEN; k++) begin
      if (trail_idx_i == 4'(k)) begin
        trail_x_d = tx_q[k];
        trail_y_d = ty_q[k];
      end
    end
  end

  // Datapath registers: trail history, velocities, trail read port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < TRAIL_LEN; k++) begin
        tx_q[k] <= XW'(X_START);
        ty_q[k] <= YW'(Y_GROUND);
      end
      vx_q      <= '0;
      vy_q      <= '0;
      trail_x_q <= '0;
      trail_y_q <= '0;
    end else begin
      if (refill) begin
        for (int k = 0; k < TRAIL_LEN; k++) begin
          tx_q[k] <= XW'(X_START);
          ty_q[k] <= YW'(Y_GROUND);
        end
      end else if (shift_en) begin
        for (int k = TRAIL_LEN - 1; k > 0; k--) begin
          tx_q[k] <= tx_q[k-1];
          ty_q[k] <= ty_q[k-1];
        end
        tx_q[0] <= head_x_d;
        ty_q[0] <= head_y_d;
      end
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      trail_x_q <= trail_x_d;
      trail_y_q <= trail_y_d;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch_i) state_d = S_FLIGHT;
      S_FLIGHT: if (land)     state_d = S_LANDED;
      S_LANDED: if (launch_i) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_flight_o = 1'b0;
    landed_o    = 1'b0;
    case (state_q)
      S_FLIGHT: in_flight_o = 1'b1;
      S_LANDED: landed_o    = 1'b1;
      default: ;
    endcase
  end

  assign ball_x_o  = tx_q[0];
  assign ball_y_o  = ty_q[0];
  assign trail_x_o = trail_x_q;
  assign trail_y_o = trail_y_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed vector table plus hand-written trail and
// coincident-event sequences for ball_motion.
module tb_ball_motion;

  logic       clk;
  logic       rst;
  logic       update;
  logic       launch;
  logic [9:0] vel_x;
  logic [9:0] vel_y;
  logic [3:0] trail_idx;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [9:0] trail_x;
  logic [8:0] trail_y;
  logic       in_flight;
  logic       landed;

  int n_checks = 0;
  int n_fail   = 0;

  ball_motion dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .update_i    (update),
    .launch_i    (launch),
    .vel_x_i     (vel_x),
    .vel_y_i     (vel_y),
    .trail_idx_i (trail_idx),
    .ball_x_o    (ball_x),
    .ball_y_o    (ball_y),
    .trail_x_o   (trail_x),
    .trail_y_o   (trail_y),
    .in_flight_o (in_flight),
    .landed_o    (landed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       launch;
    logic       update;
    logic [9:0] vx;
    logic [9:0] vy;
    logic [9:0] ex;
    logic [8:0] ey;
    logic       ef;
    logic       el;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic l, input logic u,
                              input int vx, input int vy, input int ex,
                              input int ey, input logic ef, input logic el);
    vec_t v;
    v.rst = r; v.launch = l; v.update = u;
    v.vx = 10'(vx); v.vy = 10'(vy);
    v.ex = 10'(ex); v.ey = 9'(ey);
    v.ef = ef; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst    = tbl[i].rst;
      launch = tbl[i].launch;
      update = tbl[i].update;
      vel_x  = tbl[i].vx;
      vel_y  = tbl[i].vy;
      tick();
      rst    = 1'b0;
      launch = 1'b0;
      update = 1'b0;
      chk($sformatf("row%0d ball_x", i), 32'(ball_x), 32'(tbl[i].ex));
      chk($sformatf("row%0d ball_y", i), 32'(ball_y), 32'(tbl[i].ey));
      chk($sformatf("row%0d in_flight", i), 32'(in_flight), 32'(tbl[i].ef));
      chk($sformatf("row%0d landed", i), 32'(landed), 32'(tbl[i].el));
    end
  endtask

  task automatic read_trail(input int idx, input int ex, input int ey);
    trail_idx = 4'(idx);
    tick();
    chk($sformatf("trail[%0d].x", idx), 32'(trail_x), 32'(ex));
    chk($sformatf("trail[%0d].y", idx), 32'(trail_y), 32'(ey));
  endtask

  task automatic check_trail_home();
    for (int k = 0; k < 10; k++) read_trail(k, 20, 470);
    read_trail(12, 0, 0);
    read_trail(15, 0, 0);
  endtask

  initial begin
    rst = 1'b0; update = 1'b0; launch = 1'b0;
    vel_x = '0; vel_y = '0; trail_idx = 4'd5;

    //            rst   launch update vx   vy    ex   ey   flt  lnd
    tbl[0]  = mk(1'b1, 1'b0, 1'b0,   0,    0,  20, 470, 1'b0, 1'b0);
    // basic trajectory with ignored mid-flight launch
    tbl[1]  = mk(1'b0, 1'b1, 1'b0,   5,   10,  20, 470, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1,   0,    0,  25, 460, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1,   0,    0,  30, 451, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0,   9,    9,  30, 451, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1,   0,    0,  35, 443, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0,   0,    0,  35, 443, 1'b1, 1'b0);
    // ground landing, launch+update together takes launch only
    tbl[7]  = mk(1'b1, 1'b0, 1'b0,   0,    0,  20, 470, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1,   0,    2,  20, 470, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 468, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 467, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 467, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 468, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 470, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 470, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b1, 1'b0,   0,    0,  20, 470, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 1'b1,   0,    0,  20, 470, 1'b0, 1'b0);
    // right wall
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 700,   20,  20, 470, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 1'b1,   0,    0, 630, 450, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 1'b1, 1'b0,   0,    0,  20, 470, 1'b0, 1'b0);
    // ceiling: clamp with vy=0, then gravity resumes
    tbl[20] = mk(1'b0, 1'b1, 1'b0,   1, 1000,  20, 470, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 1'b0, 1'b1,   0,    0,  21,   0, 1'b1, 1'b0);
    tbl[22] = mk(1'b0, 1'b0, 1'b1,   0,    0,  22,   0, 1'b1, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 1'b1,   0,    0,  23,   1, 1'b1, 1'b0);
    tbl[24] = mk(1'b0, 1'b0, 1'b1,   0,    0,  24,   3, 1'b1, 1'b0);
    // reset mid-flight overrides launch and update
    tbl[25] = mk(1'b1, 1'b1, 1'b1,   3,    3,  20, 470, 1'b0, 1'b0);
    // wall and ground on the same update
    tbl[26] = mk(1'b0, 1'b1, 1'b0, 700,    0,  20, 470, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 1'b0, 1'b1,   0,    0, 630, 470, 1'b0, 1'b1);

    // Reset: read port cleared, then full trail read-back
    run_rows(0, 0);
    chk("reset trail_x", 32'(trail_x), 32'd0);
    chk("reset trail_y", 32'(trail_y), 32'd0);
    check_trail_home();

    // Basic trajectory and its trail
    run_rows(1, 6);
    read_trail(0, 35, 443);
    read_trail(1, 30, 451);
    read_trail(2, 25, 460);
    read_trail(3, 20, 470);
    for (int k = 4; k < 10; k++) read_trail(k, 20, 470);
    read_trail(12, 0, 0);

    // Ground landing, re-arm, ignored update in IDLE
    run_rows(7, 16);

    // Right wall then re-arm refills the trail
    run_rows(17, 18);
    read_trail(0, 630, 450);
    read_trail(1, 20, 470);
    run_rows(19, 19);
    check_trail_home();

    // Ceiling
    run_rows(20, 24);

    // Read coinciding with an update sees the pre-shift head
    trail_idx = 4'd0;
    update    = 1'b1;
    tick();
    update    = 1'b0;
    chk("coincident trail_x", 32'(trail_x), 32'd24);
    chk("coincident trail_y", 32'(trail_y), 32'd3);
    chk("coincident ball_x", 32'(ball_x), 32'd25);
    chk("coincident ball_y", 32'(ball_y), 32'd6);
    // Back-to-back update steps again
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("b2b ball_x", 32'(ball_x), 32'd26);
    chk("b2b ball_y", 32'(ball_y), 32'd10);
    read_trail(1, 25, 6);

    // Reset mid-flight
    trail_idx = 4'd1;
    run_rows(25, 25);
    chk("midrst trail_x", 32'(trail_x), 32'd0);
    chk("midrst trail_y", 32'(trail_y), 32'd0);
    check_trail_home();

    // Wall plus ground together
    run_rows(26, 27);
    read_trail(0, 630, 470);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
